// File: rtl/iir_decim_out.sv
// iir_decim_out: decimating output stage for iir_N.
// Integrates DEC = 2**LOG2DEC samples, emits the rounded and saturated mean
// through a 2-entry valid/ready FIFO, and keeps sticky overrun/saturation flags.
module iir_decim_out #(
  parameter int BITWIDTH = 32,
  parameter int LOG2DEC  = 2,
  parameter int OUTW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] x_in,
  input  logic                in_en,
  output logic [OUTW-1:0]     dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                ovr_flag,
  output logic                sat_flag,
  input  logic                clr_flags
);

  localparam int DEC  = 1 << LOG2DEC;
  localparam int ACCW = BITWIDTH + LOG2DEC;   // wide enough for DEC full-scale samples
  localparam int RW   = ACCW + 1;             // headroom for the rounding offset
  localparam int CW   = (LOG2DEC > 0) ? LOG2DEC : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(DEC - 1);
  localparam logic signed [RW-1:0] MAXV     = RW'((longint'(1) <<< (OUTW - 1)) - 1);
  localparam logic signed [RW-1:0] MINV     = RW'(-(longint'(1) <<< (OUTW - 1)));

  logic signed [ACCW-1:0] r_acc;
  logic [CW-1:0]          r_cnt;

  logic signed [ACCW-1:0] w_sum;
  logic signed [RW-1:0]   w_rnd;
  logic                   w_dump;
  logic                   w_hi;
  logic                   w_lo;
  logic                   w_clip;
  logic [OUTW-1:0]        w_res;

  // Running sum including the sample on the input this cycle.
  assign w_sum  = r_acc + ACCW'($signed(x_in));
  assign w_dump = in_en & (r_cnt == CNT_LAST);

  // Mean with round-half-up; a plain pass-through when there is no decimation.
  generate
    if (LOG2DEC == 0) begin : g_nodec
      assign w_rnd = RW'(w_sum);
    end else begin : g_dec
      assign w_rnd = (RW'(w_sum) + RW'(longint'(1) <<< (LOG2DEC - 1))) >>> LOG2DEC;
    end
  endgenerate

  assign w_hi   = (w_rnd > MAXV);
  assign w_lo   = (w_rnd < MINV);
  assign w_clip = w_hi | w_lo;
  assign w_res  = w_hi ? MAXV[OUTW-1:0] : (w_lo ? MINV[OUTW-1:0] : w_rnd[OUTW-1:0]);

  // Accumulate samples; the dump edge restarts the frame from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (in_en) begin
      if (w_dump) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // ---------------- 2-entry output FIFO ----------------
  logic [OUTW-1:0] r_mem [2];
  logic            r_rd;
  logic            r_wr;
  logic [1:0]      r_occ;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign dout_valid = (r_occ != 2'd0);
  assign w_full     = (r_occ == 2'd2);
  assign w_pop      = dout_valid & dout_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_push     = w_dump & (~w_full | w_pop);
  assign w_drop     = w_dump & w_full & ~w_pop;
  assign dout       = dout_valid ? r_mem[r_rd] : '0;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wr] <= w_res;
      r_wr <= r_wr ^ w_push;
      r_rd <= r_rd ^ w_pop;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Sticky flags; a set on the clearing edge takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_flag <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      ovr_flag <= (ovr_flag & ~clr_flags) | w_drop;
      sat_flag <= (sat_flag & ~clr_flags) | (w_dump & w_clip);
    end
  end

endmodule
